branch_predict_unit: RTL and testbench

//  Fetch-stage redirect unit; parametrised successor to the early-jump decoder.

---
 rtl/branch_predict_unit_pkg.sv | 37 +++
 rtl/branch_predict_unit_if.sv | 26 ++
 rtl/branch_predict_unit_ras.sv | 51 +++++
 rtl/branch_predict_unit.sv | 103 ++++++++++
 tb/tb_branch_predict_unit.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_predict_unit_pkg.sv
// Shared fetch-prediction definitions: RISC-V opcodes, BHT counter encodings and immediate decode.
package rv_pred_pkg;

   localparam int IMM_XLEN = 32;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } ctr_e;

   // x1 (ra) and x5 (t0) are the RISC-V link registers for call/return hints.
   function automatic logic is_link(input logic [4:0] r);
      return (r == 5'd1) || (r == 5'd5);
   endfunction

   function automatic logic signed [IMM_XLEN-1:0] imm_j(input logic [31:0] instr);
      return IMM_XLEN'(signed'({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
   endfunction

   function automatic logic signed [IMM_XLEN-1:0] imm_b(input logic [31:0] instr);
      return IMM_XLEN'(signed'({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
   endfunction

   function automatic logic [1:0] ctr_update(input logic [1:0] c, input logic taken);
      if (taken) begin
         return (c == CTR_ST) ? c : c + 2'd1;
      end
      return (c == CTR_SNT) ? c : c - 2'd1;
   endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch-side bundle between instruction memory / EX resolution and the branch predictor.
interface branch_predict_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] pc;
   logic [31:0]     instr;
   logic            instr_valid;
   logic            stall;
   logic            flush;
   logic            upd_valid;
   logic [XLEN-1:0] upd_pc;
   logic            upd_taken;
   logic            jump_flag;
   logic [XLEN-1:0] jump_address;
   logic            pred_taken;

   modport master (
      output pc, instr, instr_valid, stall, flush, upd_valid, upd_pc, upd_taken,
      input  jump_flag, jump_address, pred_taken
   );

   modport slave (
      input  pc, instr, instr_valid, stall, flush, upd_valid, upd_pc, upd_taken,
      output jump_flag, jump_address, pred_taken
   );
endinterface

// File: rtl/branch_predict_unit_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module return_addr_stack #(
   parameter int XLEN      = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  logic            pop,
   input  logic            flush,
   input  logic [XLEN-1:0] push_data,
   output logic [XLEN-1:0] top,
   output logic            empty
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(RAS_DEPTH);

   logic [XLEN-1:0]  entries [RAS_DEPTH];
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] top_idx;
   logic [PTR_W:0]   count;

   assign top_idx = ptr - PTR_W'(1);
   assign top     = entries[top_idx];
   assign empty   = (count == '0);

   // ptr names the next free slot; when full it also names the oldest entry, so wrapping overwrites it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr   <= '0;
         count <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else if (flush) begin
         ptr   <= '0;
         count <= '0;
      end else if (push) begin
         entries[ptr] <= push_data;
         ptr          <= ptr + PTR_W'(1);
         if (count != FULL_CNT) begin
            count <= count + (PTR_W + 1)'(1);
         end
      end else if (pop && !empty) begin
         ptr   <= top_idx;
         count <= count - (PTR_W + 1)'(1);
      end
   end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-stage branch predictor: same-cycle redirect for JAL, conditional branches (2-bit BHT) and returns (RAS).
module branch_predict_unit
   import rv_pred_pkg::*;
#(
   parameter int         XLEN      = 32,
   parameter int         BHT_IDX_W = 6,
   parameter int         RAS_DEPTH = 4,
   parameter logic [1:0] INIT_CTR  = CTR_WNT
) (
   input logic             clk,
   input logic             reset,
   branch_predict_if.slave bus
);

   localparam int BHT_N = 1 << BHT_IDX_W;

   logic [1:0]           bht [BHT_N];
   logic [BHT_IDX_W-1:0] rd_idx;
   logic [BHT_IDX_W-1:0] upd_idx;
   logic [6:0]           opcode;
   logic [4:0]           rd;
   logic [4:0]           rs1;
   logic [XLEN-1:0]      imm_j_x;
   logic [XLEN-1:0]      imm_b_x;
   logic [XLEN-1:0]      ras_top;
   logic                 ras_empty;
   logic                 push_req;
   logic                 pop_req;
   logic                 jump_flag;
   logic [XLEN-1:0]      jump_address;
   logic                 pred_taken;

   assign opcode  = bus.instr[6:0];
   assign rd      = bus.instr[11:7];
   assign rs1     = bus.instr[19:15];
   assign rd_idx  = bus.pc[BHT_IDX_W+1:2];
   assign upd_idx = bus.upd_pc[BHT_IDX_W+1:2];
   assign imm_j_x = XLEN'(imm_j(bus.instr));
   assign imm_b_x = XLEN'(imm_b(bus.instr));

   // Reset is folded in here so the outputs drop the moment reset asserts, not at the next edge.
   always_comb begin
      jump_flag    = 1'b0;
      jump_address = '0;
      pred_taken   = 1'b0;
      push_req     = 1'b0;
      pop_req      = 1'b0;
      if (reset && bus.instr_valid) begin
         case (opcode)
            OPC_JAL: begin
               jump_flag    = 1'b1;
               jump_address = bus.pc + imm_j_x;
               push_req     = is_link(rd);
            end
            OPC_JALR: begin
               if (is_link(rd)) begin
                  push_req = 1'b1;
               end else if (is_link(rs1) && !ras_empty) begin
                  jump_flag    = 1'b1;
                  jump_address = ras_top;
                  pop_req      = 1'b1;
               end
            end
            OPC_BRANCH: begin
               pred_taken   = bht[rd_idx][1];
               jump_flag    = pred_taken;
               jump_address = bus.pc + imm_b_x;
            end
            default: ;
         endcase
      end
   end

   assign bus.jump_flag    = jump_flag;
   assign bus.jump_address = jump_address;
   assign bus.pred_taken   = pred_taken;

   // No read bypass: a same-index fetch this cycle sees the counter before this update lands.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < BHT_N; i++) begin
            bht[i] <= INIT_CTR;
         end
      end else if (bus.upd_valid) begin
         bht[upd_idx] <= ctr_update(bht[upd_idx], bus.upd_taken);
      end
   end

   return_addr_stack #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (push_req && !bus.stall),
      .pop       (pop_req && !bus.stall),
      .flush     (bus.flush),
      .push_data (bus.pc + XLEN'(4)),
      .top       (ras_top),
      .empty     (ras_empty)
   );

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: a queue/array reference model predicts each fetch's outputs.
module tb_branch_predict_unit;

   localparam int         XLEN      = 32;
   localparam int         BHT_IDX_W = 6;
   localparam int         RAS_DEPTH = 4;
   localparam logic [1:0] INIT_CTR  = 2'b01;
   localparam int         BHT_N     = 1 << BHT_IDX_W;

   typedef struct {
      logic            jf;
      logic [XLEN-1:0] ja;
      logic            pt;
      string           tag;
   } exp_t;

   logic clk;
   logic reset;

   branch_predict_if #(.XLEN(XLEN)) bus ();

   branch_predict_unit #(
      .XLEN      (XLEN),
      .BHT_IDX_W (BHT_IDX_W),
      .RAS_DEPTH (RAS_DEPTH),
      .INIT_CTR  (INIT_CTR)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   exp_t            exp_q [$];
   int              n_vectors     = 0;
   int              n_miscompares = 0;
   int              m_ctr [BHT_N];
   logic [XLEN-1:0] m_ras [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic ref_link(input logic [4:0] r);
      return (r == 5'd1) || (r == 5'd5);
   endfunction

   // Immediates as plain signed integers: field value minus 2**width when the sign bit is set.
   function automatic logic [31:0] ref_imm_j(input logic [31:0] i);
      int v;
      v = int'({i[31], i[19:12], i[20], i[30:21], 1'b0});
      if (i[31]) v = v - (1 << 21);
      return v;
   endfunction

   function automatic logic [31:0] ref_imm_b(input logic [31:0] i);
      int v;
      v = int'({i[31], i[7], i[30:25], i[11:8], 1'b0});
      if (i[31]) v = v - (1 << 13);
      return v;
   endfunction

   function automatic logic [31:0] enc_jal(input logic [4:0] rd, input int imm);
      logic [20:0] b;
      b = imm[20:0];
      return {b[20], b[10:1], b[11], b[19:12], rd, 7'b1101111};
   endfunction

   function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
      return {12'h000, rs1, 3'b000, rd, 7'b1100111};
   endfunction

   function automatic logic [31:0] enc_beq(input int imm);
      logic [12:0] b;
      b = imm[12:0];
      return {b[12], b[10:5], 5'd2, 5'd1, 3'b000, b[4:1], b[11], 7'b1100011};
   endfunction

   function automatic logic [4:0] pick_reg();
      case ($urandom_range(0, 3))
         0:       return 5'd0;
         1:       return 5'd1;
         2:       return 5'd5;
         default: return 5'($urandom_range(2, 31));
      endcase
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < BHT_N; i++) m_ctr[i] = int'(INIT_CTR);
      m_ras.delete();
   endfunction

   task automatic check_output(input exp_t e);
      n_vectors++;
      if (bus.jump_flag !== e.jf) begin
         n_miscompares++;
         $display("[TB] FAIL %s jump_flag: got %0b, expected %0b", e.tag, bus.jump_flag, e.jf);
      end
      if (bus.jump_address !== e.ja) begin
         n_miscompares++;
         $display("[TB] FAIL %s jump_address: got %h, expected %h", e.tag, bus.jump_address, e.ja);
      end
      if (bus.pred_taken !== e.pt) begin
         n_miscompares++;
         $display("[TB] FAIL %s pred_taken: got %0b, expected %0b", e.tag, bus.pred_taken, e.pt);
      end
   endtask

   // Drives one cycle, predicts its outputs from the model, then advances the model past the next edge.
   task automatic apply_stimulus(input logic v, input logic [XLEN-1:0] pc, input logic [31:0] instr,
                                 input logic stall, input logic flush, input logic uv,
                                 input logic [XLEN-1:0] upc, input logic ut, input string tag);
      exp_t e;
      logic do_push, do_pop;
      int   idx;
      @(posedge clk);
      #1;
      bus.instr_valid = v;
      bus.pc          = pc;
      bus.instr       = instr;
      bus.stall       = stall;
      bus.flush       = flush;
      bus.upd_valid   = uv;
      bus.upd_pc      = upc;
      bus.upd_taken   = ut;
      e.jf = 1'b0; e.ja = '0; e.pt = 1'b0; e.tag = tag;
      do_push = 1'b0;
      do_pop  = 1'b0;
      if (v) begin
         case (instr[6:0])
            7'b1101111: begin
               e.jf    = 1'b1;
               e.ja    = pc + ref_imm_j(instr);
               do_push = ref_link(instr[11:7]);
            end
            7'b1100111: begin
               if (ref_link(instr[11:7])) do_push = 1'b1;
               else if (ref_link(instr[19:15]) && m_ras.size() > 0) begin
                  e.jf   = 1'b1;
                  e.ja   = m_ras[$];
                  do_pop = 1'b1;
               end
            end
            7'b1100011: begin
               idx  = int'(pc >> 2) % BHT_N;
               e.pt = (m_ctr[idx] >= 2);
               e.jf = e.pt;
               e.ja = pc + ref_imm_b(instr);
            end
            default: ;
         endcase
      end
      exp_q.push_back(e);
      if (uv) begin
         idx = int'(upc >> 2) % BHT_N;
         if (ut) m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
         else    m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
      end
      if (flush) m_ras.delete();
      else if (v && !stall) begin
         if (do_push) begin
            m_ras.push_back(pc + 4);
            if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
         end else if (do_pop) begin
            void'(m_ras.pop_back());
         end
      end
   endtask

   task automatic fetch(input logic [XLEN-1:0] pc, input logic [31:0] instr, input string tag);
      apply_stimulus(1'b1, pc, instr, 1'b0, 1'b0, 1'b0, '0, 1'b0, tag);
   endtask

   task automatic train(input logic [XLEN-1:0] upc, input logic ut, input string tag);
      apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, upc, ut, tag);
   endtask

   // A live JAL is presented while reset is low, so any output leaking through reset shows up.
   task automatic pulse_reset();
      exp_t e;
      @(posedge clk);
      #1;
      reset           = 1'b0;
      bus.instr_valid = 1'b1;
      bus.pc          = 32'h40;
      bus.instr       = enc_jal(5'd1, 32'h80);
      bus.stall       = 1'b0;
      bus.flush       = 1'b0;
      bus.upd_valid   = 1'b0;
      e.jf = 1'b0; e.ja = '0; e.pt = 1'b0; e.tag = "reset_asserted";
      exp_q.push_back(e);
      model_reset();
      @(posedge clk);
      #1;
      reset           = 1'b1;
      bus.instr_valid = 1'b0;
      e.tag = "reset_release_idle";
      exp_q.push_back(e);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_output(e);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset           = 1'b0;
      bus.instr_valid = 1'b0;
      bus.pc          = '0;
      bus.instr       = '0;
      bus.stall       = 1'b0;
      bus.flush       = 1'b0;
      bus.upd_valid   = 1'b0;
      bus.upd_pc      = '0;
      bus.upd_taken   = 1'b0;
      model_reset();
      pulse_reset();

      fetch(32'h100, enc_beq(16), "beq_init_not_taken");
      train(32'h100, 1'b1, "train_t1");
      train(32'h100, 1'b1, "train_t2");
      fetch(32'h200, enc_beq(16), "beq_alias_taken");

      for (int k = 0; k < 4; k++) begin
         apply_stimulus(1'b1, 32'h100, enc_beq(16), 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, "beq_decay");
      end
      fetch(32'h100, enc_beq(-32), "beq_saturated_low");

      fetch(32'h40, enc_jal(5'd1, 32'h80), "jal_call");
      fetch(32'hC8, enc_jalr(5'd0, 5'd1), "ret_hit");
      fetch(32'hC8, enc_jalr(5'd0, 5'd1), "ret_empty");

      for (int k = 0; k < 5; k++) begin
         fetch(32'h1000 + 32'(k) * 32'h100, enc_jal(5'd1, 8), "call_chain");
      end
      for (int k = 0; k < 5; k++) begin
         fetch(32'h2000, enc_jalr(5'd0, 5'd5), "ret_chain");
      end

      fetch(32'h300, enc_jal(5'd5, -16), "call_before_stall");
      for (int k = 0; k < 3; k++) begin
         apply_stimulus(1'b1, 32'h500, enc_jalr(5'd0, 5'd1), 1'b1, 1'b0, 1'b1, 32'h104, 1'b1, "ret_stalled");
      end
      apply_stimulus(1'b1, 32'h500, enc_jalr(5'd0, 5'd1), 1'b0, 1'b1, 1'b0, '0, 1'b0, "ret_flushed");
      fetch(32'h500, enc_jalr(5'd0, 5'd1), "ret_after_flush");
      fetch(32'h104, enc_beq(64), "beq_trained_under_stall");

      for (int i = 0; i < 400; i++) begin
         logic [31:0] ins;
         logic [4:0]  rd;
         logic [4:0]  rs1;
         int          kind;
         if (i == 200) begin
            pulse_reset();
            fetch(32'h100, enc_beq(16), "beq_after_reset");
            train(32'h100, 1'b1, "train_after_reset");
            fetch(32'h100, enc_beq(16), "beq_after_reset_trained");
         end
         ins  = $urandom;
         rd   = pick_reg();
         rs1  = pick_reg();
         kind = $urandom_range(0, 4);
         case (kind)
            0:       ins = {ins[31:12], rd, 7'b1101111};
            1:       ins = {ins[31:20], rs1, ins[14:12], rd, 7'b1100111};
            2, 3:    ins = {ins[31:7], 7'b1100011};
            default: ;
         endcase
         apply_stimulus($urandom_range(0, 99) < 85, $urandom & 32'h0000_0FFC, ins,
                        $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 5,
                        1'($urandom_range(0, 1)), $urandom & 32'h0000_0FFC,
                        $urandom_range(0, 99) < 60, "random");
      end

      @(negedge clk);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         n_miscompares++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
